mem_port_arbiter: RTL and testbench

- Shares the single-port unified memory between instruction fetch (IF) and the load/store path (LS) of the 3-stage RISC-V core.
- Registers one request at a time and drives it on the memory port.
- Returns read data with a one-cycle ready pulse to the requester it granted.
- Enforces bounded LS priority and a response timeout, and provides the stall signals used by the pipeline control.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch (IF)
// and the load/store path (LS) of the 3-stage core.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   if_*              fetch request (if_req/if_addr) and response
//                     (if_rdata/if_ready/if_err)
//   ls_*              load/store request (ls_req/ls_we/ls_mask/ls_addr/
//                     ls_wdata) and response (ls_rdata/ls_ready/ls_err)
//   mem_*             registered memory request, held until mem_ack
//   stall_if/stall_ls pipeline stalls: request pending and not yet ready
module mem_port_arbiter #(
    parameter int unsigned MAX_LS_STREAK = 4,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    output logic        if_err,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [3:0]  ls_mask,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_ready,
    output logic        ls_err,

    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,

    output logic        stall_if,
    output logic        stall_ls
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t     state;
    owner_t     owner;
    logic [3:0] ls_streak;
    logic [7:0] tmo_cnt;

    logic grant_ls;
    logic grant_if;
    logic tmo_hit;

    // LS wins ties until it has taken MAX_LS_STREAK grants in a row
    // while fetch was waiting; then fetch gets one slot.
    assign grant_ls = ls_req & (~if_req | (ls_streak != STREAK_MAX));
    assign grant_if = if_req & ~grant_ls;
    assign tmo_hit  = (tmo_cnt == TMO_LAST);

    assign stall_if = if_req & ~if_ready;
    assign stall_ls = ls_req & ~ls_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            owner     <= OWN_IF;
            ls_streak <= '0;
            tmo_cnt   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_mask  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            if_ready  <= 1'b0;
            if_err    <= 1'b0;
            ls_rdata  <= '0;
            ls_ready  <= 1'b0;
            ls_err    <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            ls_ready <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    // Streak only counts LS grants taken while fetch waits;
                    // any idle slot without a fetch request restarts it.
                    if (grant_ls && if_req) begin
                        ls_streak <= ls_streak + 4'd1;
                    end else begin
                        ls_streak <= '0;
                    end

                    unique case (1'b1)
                        grant_ls: begin
                            owner     <= OWN_LS;
                            mem_req   <= 1'b1;
                            mem_we    <= ls_we;
                            mem_mask  <= ls_mask;
                            mem_addr  <= ls_addr;
                            mem_wdata <= ls_wdata;
                            tmo_cnt   <= '0;
                            state     <= S_BUSY;
                        end
                        grant_if: begin
                            owner     <= OWN_IF;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_mask  <= '0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            tmo_cnt   <= '0;
                            state     <= S_BUSY;
                        end
                        default: begin
                            state <= S_IDLE;
                        end
                    endcase
                end

                S_BUSY: begin
                    // An ack in the expiry cycle still completes normally.
                    if (mem_ack || tmo_hit) begin
                        mem_req <= 1'b0;
                        state   <= S_RESP;
                        if (owner == OWN_LS) begin
                            ls_ready <= 1'b1;
                            ls_err   <= ~mem_ack;
                            ls_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            if_ready <= 1'b1;
                            if_err   <= ~mem_ack;
                            if_rdata <= mem_ack ? mem_rdata : '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                S_RESP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, a transaction-level
// reference model checked every cycle, and literal expectations.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_mask;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_ready;
    logic        ls_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_ls;

    mem_port_arbiter #(
        .MAX_LS_STREAK(MAXS),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_mask(ls_mask),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata),
        .ls_ready(ls_ready), .ls_err(ls_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_mask(mem_mask),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_ls(stall_ls)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Phase of the one outstanding transaction: 0 none, 1 on the
    // memory port, 2 response cycle.
    int          m_ph;
    bit          m_ls;
    int          m_waited;
    int          m_streak;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    logic [3:0]  m_mask;
    logic [31:0] m_if_rd, m_ls_rd;
    logic        m_if_err, m_ls_err;

    task automatic m_done(input logic [31:0] rd, input logic e);
        if (m_ls) begin m_ls_rd = rd; m_ls_err = e; end
        else begin m_if_rd = rd; m_if_err = e; end
        m_ph = 2;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph = 0; m_ls = 0; m_waited = 0; m_streak = 0;
            m_addr = 0; m_wdata = 0; m_we = 0; m_mask = 0;
            m_if_rd = 0; m_ls_rd = 0; m_if_err = 0; m_ls_err = 0;
        end else begin
            case (m_ph)
                0: begin
                    bit take_ls;
                    take_ls = ls_req && (!if_req || m_streak < MAXS);
                    m_streak = (take_ls && if_req) ? m_streak + 1 : 0;
                    if (take_ls) begin
                        m_ls = 1; m_addr = ls_addr; m_we = ls_we;
                        m_mask = ls_mask; m_wdata = ls_wdata;
                        m_ph = 1; m_waited = 0;
                    end else if (if_req) begin
                        m_ls = 0; m_addr = if_addr; m_we = 0;
                        m_mask = 0; m_wdata = 0;
                        m_ph = 1; m_waited = 0;
                    end
                end
                1: begin
                    m_waited++;
                    if (mem_ack) m_done(mem_rdata, 1'b0);
                    else if (m_waited == TMO) m_done(32'h0, 1'b1);
                end
                default: m_ph = 0;
            endcase
        end
    end

    bit chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic e_ifr, e_lsr;
            e_ifr = (m_ph == 2) && !m_ls;
            e_lsr = (m_ph == 2) && m_ls;
            chk("mem_req", {31'b0, mem_req}, {31'b0, m_ph == 1});
            chk("mem_we", {31'b0, mem_we}, {31'b0, m_we});
            chk("mem_mask", {28'b0, mem_mask}, {28'b0, m_mask});
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("if_ready", {31'b0, if_ready}, {31'b0, e_ifr});
            chk("ls_ready", {31'b0, ls_ready}, {31'b0, e_lsr});
            chk("if_rdata", if_rdata, m_if_rd);
            chk("ls_rdata", ls_rdata, m_ls_rd);
            chk("if_err", {31'b0, if_err}, {31'b0, m_if_err});
            chk("ls_err", {31'b0, ls_err}, {31'b0, m_ls_err});
            chk("stall_if", {31'b0, stall_if},
                {31'b0, if_req & ~e_ifr});
            chk("stall_ls", {31'b0, stall_ls},
                {31'b0, ls_req & ~e_lsr});
        end
    end

    // ---------------- stimulus ----------------
    int          ack_at;
    int          req_cycles;
    bit          stray_ack;
    logic [31:0] rd_val;
    bit          prev_req;
    int          grants[$];
    int          if_rdy_cnt, ls_rdy_cnt;

    // One cycle: memory responder, grant logger and requesters that drop
    // their request on the ready pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_req) begin
            req_cycles++;
            mem_ack = (ack_at != 0) && (req_cycles == ack_at);
        end else begin
            req_cycles = 0;
            mem_ack = stray_ack;
        end
        mem_rdata = rd_val;
        if (mem_req && !prev_req)
            grants.push_back((mem_addr == if_addr) ? 0 : 1);
        prev_req = mem_req;
        if (if_ready) begin if_rdy_cnt++; if_req = 0; end
        if (ls_ready) ls_rdy_cnt++;
    endtask

    task automatic wait_ls(input int maxc, output int cyc, output int reqs);
        cyc = -1; reqs = 0;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if (mem_req) reqs++;
            if (ls_ready) begin cyc = i; ls_req = 0; break; end
        end
        if (cyc < 0) chk("wait_ls_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_streak(input string tag);
        int exp_g[6];
        exp_g = '{1, 1, 1, 1, 0, 1};
        grants.delete();
        ack_at = 1;
        if_req = 1; if_addr = 32'h8000_0040;
        ls_req = 1; ls_we = 0; ls_mask = 4'hF;
        ls_addr = 32'h0000_2000; ls_wdata = 0;
        for (int i = 0; i < 100 && grants.size() < 6; i++) tick();
        ls_req = 0;
        for (int i = 0; i < 8; i++) tick();
        chk({tag, "_ngrants"}, grants.size(), 32'd6);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            chk($sformatf("%s_grant%0d", tag, i), grants[i], exp_g[i]);
    endtask

    initial begin
        int cyc, reqs, r0;
        rst = 0;
        if_req = 0; if_addr = 0;
        ls_req = 0; ls_we = 0; ls_mask = 0; ls_addr = 0; ls_wdata = 0;
        mem_rdata = 0; mem_ack = 0;
        ack_at = 1; req_cycles = 0; stray_ack = 0; rd_val = 0;
        prev_req = 0; if_rdy_cnt = 0; ls_rdy_cnt = 0;
        tick();
        chk_en = 1;
        tick();
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        rst = 1;
        tick();

        // Single fetch read.
        ack_at = 1; rd_val = 32'h0010_0093;
        if_req = 1; if_addr = 32'h0000_0010;
        r0 = ls_rdy_cnt; cyc = -1; reqs = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (mem_req) reqs++;
            if (if_ready) begin
                cyc = i;
                chk("t1_if_rdata", if_rdata, 32'h0010_0093);
                chk("t1_if_err", {31'b0, if_err}, 32'd0);
                break;
            end
        end
        chk("t1_ready_cycle", cyc, 32'd2);
        chk("t1_req_cycles", reqs, 32'd1);
        chk("t1_no_ls_ready", ls_rdy_cnt - r0, 32'd0);
        tick(); tick();

        // Stray ack while idle must be ignored.
        stray_ack = 1;
        r0 = if_rdy_cnt + ls_rdy_cnt;
        tick(); tick();
        stray_ack = 0;
        tick(); tick();
        chk("stray_ack_ready", if_rdy_cnt + ls_rdy_cnt - r0, 32'd0);

        // Simultaneous fetch and store.
        grants.delete();
        rd_val = 32'h1111_2222;
        if_req = 1; if_addr = 32'h8000_0020;
        ls_req = 1; ls_we = 1; ls_mask = 4'b0011;
        ls_addr = 32'h0000_0100; ls_wdata = 32'hDEAD_BEEF;
        r0 = if_rdy_cnt;
        tick();
        chk("t2_mem_we", {31'b0, mem_we}, 32'd1);
        chk("t2_mem_mask", {28'b0, mem_mask}, 32'b0011);
        chk("t2_mem_addr", mem_addr, 32'h0000_0100);
        chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        wait_ls(20, cyc, reqs);
        for (int i = 0; i < 20 && if_req; i++) tick();
        tick(); tick();
        chk("t2_if_ready_once", if_rdy_cnt - r0, 32'd1);
        chk("t2_ngrants", grants.size(), 32'd2);
        if (grants.size() == 2) begin
            chk("t2_first_ls", grants[0], 32'd1);
            chk("t2_second_if", grants[1], 32'd0);
        end

        // LS held continuously against a waiting fetch.
        run_streak("t3");

        // Timeout, then a good access clears err.
        ack_at = 0; rd_val = 32'hFFFF_FFFF;
        ls_req = 1; ls_we = 0; ls_mask = 4'hF; ls_addr = 32'h0000_3000;
        wait_ls(30, cyc, reqs);
        chk("t4_req_cycles", reqs, 32'd8);
        chk("t4_ls_err", {31'b0, ls_err}, 32'd1);
        chk("t4_ls_rdata", ls_rdata, 32'd0);
        tick();
        ack_at = 2; rd_val = 32'h1234_5678;
        ls_req = 1; ls_addr = 32'h0000_3004;
        wait_ls(30, cyc, reqs);
        chk("t4b_ls_err", {31'b0, ls_err}, 32'd0);
        chk("t4b_ls_rdata", ls_rdata, 32'h1234_5678);
        tick();

        // Ack in the same cycle the timeout expires.
        ack_at = TMO; rd_val = 32'hCAFE_F00D;
        ls_req = 1; ls_addr = 32'h0000_3008;
        wait_ls(30, cyc, reqs);
        chk("t5_req_cycles", reqs, 32'd8);
        chk("t5_ls_err", {31'b0, ls_err}, 32'd0);
        chk("t5_ls_rdata", ls_rdata, 32'hCAFE_F00D);
        tick();

        // Reset during BUSY after an LS grant has bumped the streak.
        ack_at = 0;
        if_req = 1; if_addr = 32'h8000_0080;
        ls_req = 1; ls_addr = 32'h0000_5000;
        tick(); tick(); tick();
        r0 = if_rdy_cnt + ls_rdy_cnt;
        chk("t6_busy_before_rst", {31'b0, mem_req}, 32'd1);
        #1 rst = 0;
        #1 chk("t6_req_dropped", {31'b0, mem_req}, 32'd0);
        if_req = 0; ls_req = 0;
        tick(); tick();
        rst = 1;
        tick(); tick();
        chk("t6_no_ready", if_rdy_cnt + ls_rdy_cnt - r0, 32'd0);
        run_streak("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
